// File: rtl/lane_sched_pkg.sv
// Shared definitions for the lane tick scheduler.
//   state_e      : scheduler state encoding (IDLE=0, RUN=1, PAUSED=2)
//   DEF_*        : default parameter values for the scheduler top
package lane_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam int DEF_N_LANES = 4;
    localparam int DEF_PER_W   = 8;
    localparam int DEF_PERIOD  = 20;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/lane_tick_scheduler_lane_counter.sv
// One movement lane: holds the lane period and a down-counter that emits a
// one-cycle step strobe every 'period' gated ticks.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   tick_i         : base tick already gated by the RUN state
//   reload_i       : force counter to period-1 (IDLE hold / stop)
//   wr_i           : load a new period (wins over tick and reload)
//   wr_period_i    : new period, 0 disables the lane
//   step_o         : registered step strobe
module lane_counter #(
    parameter int PER_W          = 8,
    parameter int DEFAULT_PERIOD = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             reload_i,
    input  logic             wr_i,
    input  logic [PER_W-1:0] wr_period_i,
    output logic             step_o
);

    localparam logic [PER_W-1:0] DEF_P = PER_W'(DEFAULT_PERIOD);

    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;

    // Counter value to start a period from; a disabled lane parks at 0.
    function automatic logic [PER_W-1:0] start_val(input logic [PER_W-1:0] p);
        return (p == '0) ? '0 : p - 1'b1;
    endfunction

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        step_d   = 1'b0;
        if (wr_i) begin
            // A write swallows any tick on this lane: no strobe, no decrement.
            period_d = wr_period_i;
            cnt_d    = start_val(wr_period_i);
        end else begin
            // A tick coinciding with a stop still strobes under the old state,
            // but the counter is reloaded rather than advanced.
            if (tick_i && period_q != '0 && cnt_q == '0) begin
                step_d = 1'b1;
            end
            if (reload_i) begin
                cnt_d = start_val(period_q);
            end else if (tick_i && period_q != '0) begin
                cnt_d = (cnt_q == '0) ? start_val(period_q) : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= DEF_P;
            cnt_q    <= DEF_P - 1'b1;
            step_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/lane_tick_scheduler.sv
// Distributes the divider's base tick to N_LANES movement lanes, each with a
// programmable period, under a RUN/PAUSED/IDLE gate.
//   i_Clk, i_Rst_L          : clock, asynchronous active-low reset
//   i_Tick                  : base tick pulse
//   i_Start/i_Pause/i_Stop  : control pulses (priority Stop > Pause > Start)
//   i_Cfg_Wr/_Lane/_Period  : lane period write port
//   o_Lane_Step             : per-lane one-cycle step strobes
//   o_State                 : current state
//   o_Tick_Count            : base ticks consumed while running (wraps)
module lane_tick_scheduler
    import lane_sched_pkg::*;
#(
    parameter int N_LANES        = DEF_N_LANES,
    parameter int PER_W          = DEF_PER_W,
    parameter int DEFAULT_PERIOD = DEF_PERIOD,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic                       i_Tick,
    input  logic                       i_Start,
    input  logic                       i_Pause,
    input  logic                       i_Stop,
    input  logic                       i_Cfg_Wr,
    input  logic [$clog2(N_LANES)-1:0] i_Cfg_Lane,
    input  logic [PER_W-1:0]           i_Cfg_Period,
    output logic [N_LANES-1:0]         o_Lane_Step,
    output logic [1:0]                 o_State,
    output logic [CNT_W-1:0]           o_Tick_Count
);

    localparam int LANE_W = $clog2(N_LANES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             lane_tick;
    logic             lane_reload;

    always_comb begin
        state_d = state_q;
        if (i_Stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (i_Start) state_d = ST_RUN;
                ST_RUN:    if (i_Pause) state_d = ST_PAUSED;
                ST_PAUSED: if (i_Pause) state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Ticks are judged against the current state, so a tick arriving with a
    // pause or stop is still consumed by the run.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_q == ST_RUN && i_Tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end else if (state_q == ST_IDLE && i_Start && !i_Stop) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign lane_tick   = i_Tick && (state_q == ST_RUN);
    // IDLE keeps every lane parked at period-1; a stop reloads on its edge.
    assign lane_reload = (state_q == ST_IDLE) || i_Stop;

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic lane_wr;
            // Out-of-range lane indices never match any instance.
            assign lane_wr = i_Cfg_Wr && (i_Cfg_Lane == LANE_W'(gi));

            lane_counter #(
                .PER_W          (PER_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_lane (
                .clk_i       (i_Clk),
                .rst_ni      (i_Rst_L),
                .tick_i      (lane_tick),
                .reload_i    (lane_reload),
                .wr_i        (lane_wr),
                .wr_period_i (i_Cfg_Period),
                .step_o      (o_Lane_Step[gi])
            );
        end
    endgenerate

    assign o_State      = state_q;
    assign o_Tick_Count = tick_cnt_q;

endmodule

// File: tb/tb_lane_tick_scheduler.sv
module tb_lane_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick, start, pause, stop;
    logic        cfg_wr;
    logic [1:0]  cfg_lane;
    logic [7:0]  cfg_period;
    logic [3:0]  step;
    logic [1:0]  st;
    logic [15:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    lane_tick_scheduler #(
        .N_LANES        (4),
        .PER_W          (8),
        .DEFAULT_PERIOD (20),
        .CNT_W          (16)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Tick       (tick),
        .i_Start      (start),
        .i_Pause      (pause),
        .i_Stop       (stop),
        .i_Cfg_Wr     (cfg_wr),
        .i_Cfg_Lane   (cfg_lane),
        .i_Cfg_Period (cfg_period),
        .o_Lane_Step  (step),
        .o_State      (st),
        .o_Tick_Count (cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One tick transaction: strobe seen right after the tick edge, then one
    // idle cycle so ticks stay two cycles apart.
    task automatic do_tick(output logic [3:0] hit, output logic [3:0] after);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        hit = step;
        cyc();
        after = step;
        $display("tick  t=%0t state=%0d step=%b next=%b count=%0d", $time, st, hit, after, cnt);
    endtask

    task automatic ctl(input logic s, input logic p, input logic t);
        start = s; pause = p; stop = t;
        cyc();
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        $display("ctl   start=%b pause=%b stop=%b -> state=%0d count=%0d", s, p, t, st, cnt);
    endtask

    task automatic cfg(input logic [1:0] lane, input logic [7:0] per);
        cfg_wr = 1'b1; cfg_lane = lane; cfg_period = per;
        cyc();
        cfg_wr = 1'b0;
        $display("cfg   lane=%0d period=%0d", lane, per);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick = 0; start = 0; pause = 0; stop = 0;
        cfg_wr = 0; cfg_lane = 0; cfg_period = 0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++; if (st !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st); end
        n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_cmp++; if (step !== 4'h0) begin n_bad++; $display("FAIL reset_step: got %b want 0000", step); end
    endtask

    task automatic test_default_run();
        logic [3:0] h, a, e;
        ctl(1, 0, 0);
        n_cmp++; if (st !== 2'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", st); end
        n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL start_count: got %0d want 0", cnt); end
        for (int k = 1; k <= 60; k++) begin
            do_tick(h, a);
            e = (k % 20 == 0) ? 4'hF : 4'h0;
            n_cmp++; if (h !== e) begin n_bad++; $display("FAIL default_step tick %0d: got %b want %b", k, h, e); end
            n_cmp++; if (a !== 4'h0) begin n_bad++; $display("FAIL default_width tick %0d: got %b want 0000", k, a); end
        end
        n_cmp++; if (cnt !== 16'd60) begin n_bad++; $display("FAIL default_count: got %0d want 60", cnt); end
    endtask

    task automatic test_cfg_periods();
        logic [3:0] h, a, e;
        cfg(2'd1, 8'd3);
        cfg(2'd2, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            do_tick(h, a);
            e = (k % 3 == 0) ? 4'b0010 : 4'h0;
            n_cmp++; if (h !== e) begin n_bad++; $display("FAIL cfg_step tick %0d: got %b want %b", k, h, e); end
        end
        n_cmp++; if (cnt !== 16'd72) begin n_bad++; $display("FAIL cfg_count: got %0d want 72", cnt); end
        ctl(0, 0, 1);
        n_cmp++; if (st !== 2'd0) begin n_bad++; $display("FAIL cfg_stop_state: got %0d want 0", st); end
        cfg(2'd1, 8'd20);
        cfg(2'd2, 8'd20);
    endtask

    task automatic test_pause();
        logic [3:0] h, a, e;
        ctl(1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            do_tick(h, a);
            n_cmp++; if (h !== 4'h0) begin n_bad++; $display("FAIL pause_pre tick %0d: got %b want 0000", k, h); end
        end
        ctl(0, 1, 0);
        n_cmp++; if (st !== 2'd2) begin n_bad++; $display("FAIL pause_state: got %0d want 2", st); end
        for (int k = 1; k <= 50; k++) begin
            do_tick(h, a);
            n_cmp++; if (h !== 4'h0) begin n_bad++; $display("FAIL paused_step tick %0d: got %b want 0000", k, h); end
        end
        n_cmp++; if (cnt !== 16'd10) begin n_bad++; $display("FAIL paused_count: got %0d want 10", cnt); end
        ctl(0, 1, 0);
        n_cmp++; if (st !== 2'd1) begin n_bad++; $display("FAIL resume_state: got %0d want 1", st); end
        for (int k = 1; k <= 10; k++) begin
            do_tick(h, a);
            e = (k == 10) ? 4'hF : 4'h0;
            n_cmp++; if (h !== e) begin n_bad++; $display("FAIL resume_step tick %0d: got %b want %b", k, h, e); end
        end
        n_cmp++; if (cnt !== 16'd20) begin n_bad++; $display("FAIL resume_count: got %0d want 20", cnt); end
    endtask

    task automatic test_write_collision();
        logic [3:0] h, a, e;
        for (int k = 1; k <= 19; k++) begin
            do_tick(h, a);
            n_cmp++; if (h !== 4'h0) begin n_bad++; $display("FAIL coll_pre tick %0d: got %b want 0000", k, h); end
        end
        // All counters are now 0; lane 0 is rewritten on the striking tick.
        tick = 1'b1; cfg_wr = 1'b1; cfg_lane = 2'd0; cfg_period = 8'd5;
        cyc();
        tick = 1'b0; cfg_wr = 1'b0;
        h = step;
        cyc();
        $display("tick+cfg lane=0 period=5 step=%b count=%0d", h, cnt);
        n_cmp++; if (h !== 4'b1110) begin n_bad++; $display("FAIL coll_step: got %b want 1110", h); end
        for (int k = 1; k <= 7; k++) begin
            do_tick(h, a);
            e = (k == 5) ? 4'b0001 : 4'h0;
            n_cmp++; if (h !== e) begin n_bad++; $display("FAIL coll_post tick %0d: got %b want %b", k, h, e); end
        end
        n_cmp++; if (cnt !== 16'd47) begin n_bad++; $display("FAIL coll_count: got %0d want 47", cnt); end
    endtask

    task automatic test_stop_pause();
        logic [3:0] h, a, e;
        ctl(0, 1, 1);
        n_cmp++; if (st !== 2'd0) begin n_bad++; $display("FAIL stoppause_state: got %0d want 0", st); end
        for (int k = 1; k <= 25; k++) begin
            do_tick(h, a);
            n_cmp++; if (h !== 4'h0) begin n_bad++; $display("FAIL idle_step tick %0d: got %b want 0000", k, h); end
        end
        n_cmp++; if (cnt !== 16'd47) begin n_bad++; $display("FAIL idle_count: got %0d want 47", cnt); end
        ctl(1, 0, 0);
        n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL restart_count: got %0d want 0", cnt); end
        for (int k = 1; k <= 5; k++) begin
            do_tick(h, a);
            e = (k == 5) ? 4'b0001 : 4'h0;
            n_cmp++; if (h !== e) begin n_bad++; $display("FAIL reload_step tick %0d: got %b want %b", k, h, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] h, a, e;
        for (int k = 1; k <= 4; k++) begin
            do_tick(h, a);
            n_cmp++; if (h !== 4'h0) begin n_bad++; $display("FAIL arst_pre tick %0d: got %b want 0000", k, h); end
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_cmp++; if (step !== 4'b0001) begin n_bad++; $display("FAIL arst_strobe: got %b want 0001", step); end
        n_cmp++; if (cnt !== 16'd10) begin n_bad++; $display("FAIL arst_count_pre: got %0d want 10", cnt); end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-cycle: state=%0d step=%b count=%0d", st, step, cnt);
        n_cmp++; if (step !== 4'h0) begin n_bad++; $display("FAIL arst_step: got %b want 0000", step); end
        n_cmp++; if (st !== 2'd0) begin n_bad++; $display("FAIL arst_state: got %0d want 0", st); end
        n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", cnt); end
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        ctl(1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            do_tick(h, a);
            e = (k == 20) ? 4'hF : 4'h0;
            n_cmp++; if (h !== e) begin n_bad++; $display("FAIL arst_period tick %0d: got %b want %b", k, h, e); end
        end
        n_cmp++; if (cnt !== 16'd20) begin n_bad++; $display("FAIL arst_final_count: got %0d want 20", cnt); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_cfg_periods();
        test_pause();
        test_write_collision();
        test_stop_pause();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_tick_scheduler.md
# lane_tick_scheduler

Shares the single slow tick pulse from the game clock divider among several independent movement lanes (road/river rows). Each lane has a programmable period in base ticks and receives a one-cycle step strobe every period. A small run/pause/idle state machine gates all lanes, so game logic can start, freeze and stop motion without touching the divider.

## Interface
- N_LANES, 4, number of scheduled lanes (2..8)
- PER_W, 8, width of a lane period in base ticks
- DEFAULT_PERIOD, 20, period loaded into every lane at reset (must be nonzero)
- CNT_W, 16, width of the run-time tick counter

- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Tick  in  1  one-cycle pulse from the clock divider (base tick)
- i_Start  in  1  pulse: IDLE -> RUN
- i_Pause  in  1  pulse: toggles RUN <-> PAUSED
- i_Stop  in  1  pulse: any state -> IDLE
- i_Cfg_Wr  in  1  write strobe for a lane period
- i_Cfg_Lane  in  $clog2(N_LANES)  lane index for the write
- i_Cfg_Period  in  PER_W  new period; 0 disables the lane
- o_Lane_Step  out  N_LANES  one-cycle step strobe per lane
- o_State  out  2  current state: IDLE=0, RUN=1, PAUSED=2
- o_Tick_Count  out  CNT_W  base ticks consumed while in RUN; wraps

## Operation
- Reset (async assert, sync release): state IDLE; all periods = DEFAULT_PERIOD; all lane counters = DEFAULT_PERIOD-1; o_Lane_Step = 0; o_Tick_Count = 0.
- States:
  - IDLE: counters held at period-1; no strobes; i_Start -> RUN, clears o_Tick_Count.
  - RUN: on i_Tick, each enabled lane with counter==0 strobes and reloads period-1; otherwise decrements. o_Tick_Count += 1 per tick, wraps 2^CNT_W-1 -> 0. i_Pause -> PAUSED.
  - PAUSED: ticks ignored; counters and o_Tick_Count hold; i_Pause -> RUN (resume mid-period, no phase loss).
  - i_Stop from RUN/PAUSED -> IDLE, reloads all counters to period-1.
- Control priority in the same cycle: i_Stop > i_Pause > i_Start; i_Start ignored outside IDLE, i_Pause ignored in IDLE.
- Period P strobes a lane every P base ticks; P=1 strobes every tick; P=0 never strobes and counter holds at 0.
- Config write (any state): period[i_Cfg_Lane] <= i_Cfg_Period and counter <= i_Cfg_Period-1 (0 if period 0). A write coinciding with a tick on the same lane wins: no strobe, no decrement for that lane; other lanes proceed normally. Out-of-range i_Cfg_Lane (N_LANES not power of two) ignored.
- A tick arriving in the same cycle as a state transition is processed under the old state (e.g. tick + i_Pause in RUN is counted and may strobe).

## Timing
- o_Lane_Step registered: asserts exactly one cycle, the cycle after the i_Tick that hits counter==0.
- o_State and o_Tick_Count update the cycle after the causing input.
- Config write takes effect on the next rising edge; first strobe with new period P follows the P-th subsequent tick.
- i_Tick assumed ≥2 cycles apart; back-to-back ticks are still each processed independently.

## Structure
- Package lane_sched_pkg: state encodings (ST_IDLE, ST_RUN, ST_PAUSED), default constants.
- Sub-module lane_counter (one instance per lane via generate): period register, down-counter, load/tick/hold inputs, step output. Top holds FSM, tick counter and write decode.

## Test plan
- Reset defaults, i_Start, 60 ticks with N_LANES=4 -> each lane strobes at ticks 20, 40, 60; o_Tick_Count = 60; strobes one cycle after tick.
- Write lane 1 period 3, lane 2 period 0, run 12 ticks -> lane 1 strobes at ticks 3,6,9,12; lane 2 never; lanes 0/3 unaffected.
- RUN 10 ticks, i_Pause, 50 ticks, i_Pause, 10 ticks -> lane strobes at total run tick 20 only; o_Tick_Count = 20.
- Write to lane 0 in same cycle as a tick where counter==0 -> no strobe that cycle; next strobe after new period.
- i_Stop and i_Pause same cycle in RUN -> IDLE; counters reloaded; subsequent ticks produce no strobes and no count.
- Assert i_Rst_L low mid-RUN between clock edges -> outputs 0 immediately, state IDLE, periods back to 20.
